// File: rtl/lamp_driver_if.sv
// Command/status bundle between the light-control FSM and the lamp driver.
// The controller owns the master view; the lamp driver owns the slave view.
interface lamp_driver_if #(
    parameter int unsigned LEVEL_W = 8
);
    logic               turn_lamp_on;
    logic               turn_lamp_off;
    logic               lamp_pwm;
    logic               lampstate;
    logic               busy;
    logic               done;
    logic [LEVEL_W-1:0] level;

    modport master (
        output turn_lamp_on,
        output turn_lamp_off,
        input  lamp_pwm,
        input  lampstate,
        input  busy,
        input  done,
        input  level
    );

    modport slave (
        input  turn_lamp_on,
        input  turn_lamp_off,
        output lamp_pwm,
        output lampstate,
        output busy,
        output done,
        output level
    );
endinterface

// File: rtl/lamp_driver.sv
// Lamp-side responder: soft-start / soft-stop brightness ramp driven by
// on/off level requests, PWM lamp drive, and a done pulse when a ramp settles.
module lamp_driver #(
    parameter int unsigned STEP_CYCLES = 4,
    parameter int unsigned LEVEL_W     = 8
) (
    input logic         clk,
    input logic         reset,
    lamp_driver_if.slave bus
);
    localparam logic [1:0] S_OFF       = 2'd0;
    localparam logic [1:0] S_RAMP_UP   = 2'd1;
    localparam logic [1:0] S_ON        = 2'd2;
    localparam logic [1:0] S_RAMP_DOWN = 2'd3;

    localparam logic [LEVEL_W-1:0] MAX_LEVEL  = '1;
    localparam logic [LEVEL_W-1:0] NEAR_MAX   = MAX_LEVEL - 1'b1;
    localparam logic [LEVEL_W-1:0] ONE_LEVEL  = {{(LEVEL_W-1){1'b0}}, 1'b1};
    localparam logic [15:0]        STEP_LAST  = 16'(STEP_CYCLES - 1);

    logic [1:0]         state;
    logic [LEVEL_W-1:0] level_q;
    logic [LEVEL_W-1:0] pwm_cnt;
    logic [15:0]        step_cnt;
    logic               done_q;
    logic               pwm_q;
    logic               on_req;
    logic               off_req;
    logic               tick;

    // Off wins when both commands are present.
    assign on_req  = bus.turn_lamp_on & ~bus.turn_lamp_off;
    assign off_req = bus.turn_lamp_off;
    assign tick    = (step_cnt == STEP_LAST);

    // Ramp FSM: reversals restart the step timer with level held; the end
    // tests use >= / <= so a ramp reversed right at an end stop still saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_OFF;
            level_q  <= '0;
            step_cnt <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_OFF: begin
                    if (on_req) begin
                        state    <= S_RAMP_UP;
                        step_cnt <= '0;
                    end
                end
                S_ON: begin
                    if (off_req) begin
                        state    <= S_RAMP_DOWN;
                        step_cnt <= '0;
                    end
                end
                S_RAMP_UP: begin
                    if (off_req) begin
                        state    <= S_RAMP_DOWN;
                        step_cnt <= '0;
                    end else if (tick) begin
                        step_cnt <= '0;
                        if (level_q >= NEAR_MAX) begin
                            level_q <= MAX_LEVEL;
                            state   <= S_ON;
                            done_q  <= 1'b1;
                        end else begin
                            level_q <= level_q + 1'b1;
                        end
                    end else begin
                        step_cnt <= step_cnt + 16'd1;
                    end
                end
                S_RAMP_DOWN: begin
                    if (on_req) begin
                        state    <= S_RAMP_UP;
                        step_cnt <= '0;
                    end else if (tick) begin
                        step_cnt <= '0;
                        if (level_q <= ONE_LEVEL) begin
                            level_q <= '0;
                            state   <= S_OFF;
                            done_q  <= 1'b1;
                        end else begin
                            level_q <= level_q - 1'b1;
                        end
                    end else begin
                        step_cnt <= step_cnt + 16'd1;
                    end
                end
                default: state <= S_OFF;
            endcase
        end
    end

    // Free-running PWM carrier and registered lamp drive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt <= '0;
            pwm_q   <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            pwm_q   <= (level_q == MAX_LEVEL) | (pwm_cnt < level_q);
        end
    end

    assign bus.level     = level_q;
    assign bus.lamp_pwm  = pwm_q;
    assign bus.done      = done_q;
    assign bus.lampstate = (state == S_RAMP_UP) | (state == S_ON);
    assign bus.busy      = (state == S_RAMP_UP) | (state == S_RAMP_DOWN);
endmodule

// File: tb/tb_lamp_driver.sv
// Bench for lamp_driver: two instances (STEP_CYCLES=1 and 4) checked every
// cycle against a brightness/time model, plus directed literal expectations.
module tb_lamp_driver;
    localparam int MAXL = 255;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic on_in [2];
    logic off_in[2];

    lamp_driver_if #(.LEVEL_W(8)) bus1 ();
    lamp_driver_if #(.LEVEL_W(8)) bus4 ();

    assign bus1.turn_lamp_on  = on_in[0];
    assign bus1.turn_lamp_off = off_in[0];
    assign bus4.turn_lamp_on  = on_in[1];
    assign bus4.turn_lamp_off = off_in[1];

    lamp_driver #(.STEP_CYCLES(1), .LEVEL_W(8)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    lamp_driver #(.STEP_CYCLES(4), .LEVEL_W(8)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    logic [7:0] q_level[2];
    logic       q_pwm[2], q_ls[2], q_busy[2], q_done[2];
    assign q_level[0] = bus1.level;     assign q_level[1] = bus4.level;
    assign q_pwm[0]   = bus1.lamp_pwm;  assign q_pwm[1]   = bus4.lamp_pwm;
    assign q_ls[0]    = bus1.lampstate; assign q_ls[1]    = bus4.lampstate;
    assign q_busy[0]  = bus1.busy;      assign q_busy[1]  = bus4.busy;
    assign q_done[0]  = bus1.done;      assign q_done[1]  = bus4.done;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(string name, int act, int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The lamp is either resting (at 0 or MAX) or moving in a direction since
    // edge t0; a step lands every STEP edges after t0. pwm phase = edges since reset.
    int m_e;
    int m_level[2];
    bit m_moving[2];
    bit m_up[2];
    int m_t0[2];
    bit m_done[2];
    bit m_pwm[2];

    function automatic int step_of(int i);
        return (i == 0) ? 1 : 4;
    endfunction

    task automatic model_edge(int i, bit on, bit off);
        bit onr = on & ~off;
        int lv  = m_level[i];
        m_pwm[i]  = (lv == MAXL) || (((m_e - 1) % 256) < lv);
        m_done[i] = 1'b0;
        if (!m_moving[i]) begin
            if (lv == 0 && onr) begin
                m_moving[i] = 1'b1; m_up[i] = 1'b1; m_t0[i] = m_e;
            end else if (lv == MAXL && off) begin
                m_moving[i] = 1'b1; m_up[i] = 1'b0; m_t0[i] = m_e;
            end
        end else if (m_up[i] && off) begin
            m_up[i] = 1'b0; m_t0[i] = m_e;
        end else if (!m_up[i] && onr) begin
            m_up[i] = 1'b1; m_t0[i] = m_e;
        end else if ((m_e - m_t0[i]) % step_of(i) == 0) begin
            lv = m_up[i] ? lv + 1 : lv - 1;
            if (lv > MAXL) lv = MAXL;
            if (lv < 0) lv = 0;
            m_level[i] = lv;
            if ((m_up[i] && lv == MAXL) || (!m_up[i] && lv == 0)) begin
                m_moving[i] = 1'b0;
                m_done[i]   = 1'b1;
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_e = 0;
            for (int i = 0; i < 2; i++) begin
                m_level[i] = 0; m_moving[i] = 0; m_up[i] = 0;
                m_t0[i] = 0; m_done[i] = 0; m_pwm[i] = 0;
            end
        end else begin
            m_e++;
            for (int i = 0; i < 2; i++) model_edge(i, on_in[i], off_in[i]);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("m_level%0d", i), q_level[i], m_level[i]);
            chk($sformatf("m_pwm%0d", i),   q_pwm[i],   m_pwm[i]);
            chk($sformatf("m_done%0d", i),  q_done[i],  m_done[i]);
            chk($sformatf("m_busy%0d", i),  q_busy[i],  m_moving[i]);
            chk($sformatf("m_ls%0d", i),    q_ls[i],    m_moving[i] ? m_up[i] : (m_level[i] == MAXL));
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic pulse(int i, bit on, bit off);
        on_in[i] = on; off_in[i] = off;
        @(negedge clk);
        on_in[i] = 1'b0; off_in[i] = 1'b0;
    endtask

    task automatic count_pwm(int i, int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cnt += int'(q_pwm[i]);
        end
    endtask

    int cnt;
    int dcount;
    bit t;

    initial begin
        on_in[0] = 0; on_in[1] = 0; off_in[0] = 0; off_in[1] = 0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("rst_level", q_level[i], 0);
            chk("rst_pwm",   q_pwm[i],   0);
            chk("rst_busy",  q_busy[i],  0);
            chk("rst_ls",    q_ls[i],    0);
            chk("rst_done",  q_done[i],  0);
        end

        // Full ramp up, STEP_CYCLES=1
        pulse(0, 1, 0);
        chk("up_ls_E0", q_ls[0], 1);
        chk("up_busy_E0", q_busy[0], 1);
        chk("up_level_E0", q_level[0], 0);
        repeat (254) @(negedge clk);
        chk("up_level_E254", q_level[0], 254);
        chk("up_done_E254", q_done[0], 0);
        @(negedge clk);
        chk("up_level_E255", q_level[0], 255);
        chk("up_done_E255", q_done[0], 1);
        chk("up_busy_E255", q_busy[0], 0);
        chk("up_ls_E255", q_ls[0], 1);
        @(negedge clk);
        chk("up_done_E256", q_done[0], 0);
        count_pwm(0, 256, cnt);
        chk("pwm_full_on", cnt, 256);

        // Full ramp down
        pulse(0, 0, 1);
        chk("dn_busy_E0", q_busy[0], 1);
        chk("dn_ls_E0", q_ls[0], 0);
        chk("dn_level_E0", q_level[0], 255);
        repeat (254) @(negedge clk);
        chk("dn_level_E254", q_level[0], 1);
        @(negedge clk);
        chk("dn_level_E255", q_level[0], 0);
        chk("dn_done_E255", q_done[0], 1);
        chk("dn_busy_E255", q_busy[0], 0);
        @(negedge clk);
        count_pwm(0, 256, cnt);
        chk("pwm_full_off", cnt, 0);

        // STEP_CYCLES=4: reversal at 100 then re-reversal
        pulse(1, 1, 0);
        repeat (400) @(negedge clk);
        chk("rev_level100", q_level[1], 100);
        pulse(1, 0, 1);
        chk("rev_hold0", q_level[1], 100);
        chk("rev_busy", q_busy[1], 1);
        chk("rev_ls", q_ls[1], 0);
        chk("rev_done", q_done[1], 0);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rev_hold%0d", k), q_level[1], 100);
        end
        @(negedge clk);
        chk("rev_step99", q_level[1], 99);
        pulse(1, 1, 0);
        chk("rerev_ls", q_ls[1], 1);
        chk("rerev_level", q_level[1], 99);
        repeat (4) @(negedge clk);
        chk("rerev_climb", q_level[1], 100);

        // Simultaneous on+off: from OFF nothing, from ON ramp down
        pulse(0, 1, 1);
        chk("both_off_busy", q_busy[0], 0);
        chk("both_off_ls", q_ls[0], 0);
        @(negedge clk);
        chk("both_off_level", q_level[0], 0);
        pulse(0, 1, 0);
        repeat (255) @(negedge clk);
        chk("both_on_reached", q_level[0], 255);
        pulse(0, 1, 1);
        chk("both_on_busy", q_busy[0], 1);
        chk("both_on_ls", q_ls[0], 0);

        // Freeze STEP_CYCLES=4 instance at 64 by alternating reversals
        pulse(1, 0, 1);
        for (int k = 0; k < 3000 && m_level[1] != 64; k++) @(negedge clk);
        chk("reach64", q_level[1], 64);
        t = 1'b1;
        cnt = 0;
        for (int k = 0; k < 260; k++) begin
            on_in[1] = t; off_in[1] = ~t; t = ~t;
            @(negedge clk);
            if (k >= 4) cnt += int'(q_pwm[1]);
        end
        on_in[1] = 0; off_in[1] = 0;
        chk("duty64", cnt, 64);
        chk("freeze_level", q_level[1], 64);

        // Async reset mid ramp-up at 37
        off_in[1] = 1'b1;
        for (int k = 0; k < 2000 && (m_moving[1] || m_level[1] != 0); k++) @(negedge clk);
        off_in[1] = 1'b0;
        chk("settle_off", q_level[1], 0);
        pulse(1, 1, 0);
        for (int k = 0; k < 2000 && m_level[1] != 37; k++) @(negedge clk);
        chk("reach37", q_level[1], 37);
        #2 reset = 1'b1;
        #1;
        chk("arst_level", q_level[1], 0);
        chk("arst_pwm", q_pwm[1], 0);
        chk("arst_busy", q_busy[1], 0);
        chk("arst_done", q_done[1], 0);
        @(negedge clk);
        reset = 1'b0;
        pulse(1, 1, 0);
        chk("post_rst_ls", q_ls[1], 1);
        dcount = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            dcount += int'(q_done[1]);
        end
        chk("post_rst_no_done", dcount, 0);

        // Randomized commands, occasional reset
        for (int k = 0; k < 6000; k++) begin
            for (int i = 0; i < 2; i++) begin
                on_in[i]  = ($urandom_range(0, 39) == 0);
                off_in[i] = ($urandom_range(0, 59) == 0);
            end
            if ($urandom_range(0, 2999) == 0) begin
                #3 reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        on_in[0] = 0; on_in[1] = 0; off_in[0] = 0; off_in[1] = 0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
